// File: rtl/aes_block_uart_serializer_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the AES block UART serializer.
package aes_block_uart_serializer_pkg;

    localparam int BLOCK_W         = 128;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = BLOCK_W / BYTE_W;
    localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } ser_state_e;

    // MSB-first order is the LSB-first order with the byte index mirrored.
    function automatic logic [BYTE_W-1:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [IDX_W-1:0]   idx,
                                                   input logic               lsb_first);
        logic [IDX_W-1:0] k;
        k = lsb_first ? idx : ~idx;
        return blk[int'(k)*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/aes_block_uart_serializer_block_fifo.sv
// Single-clock block FIFO with registered count; pointers wrap modulo DEPTH (power of two).
module aes_block_uart_serializer_block_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/aes_block_uart_serializer.sv
// Buffers 128-bit AES result blocks and feeds them byte-by-byte to a uart_tx start/done handshake.
module aes_block_uart_serializer
    import aes_block_uart_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] blk_data_i,
    input  logic               blk_valid_i,
    output logic               blk_ready_o,
    output logic [BYTE_W-1:0]  tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    output logic               busy_o,
    output logic [15:0]        blocks_sent_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ser_state_e         state_q, state_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [15:0]        sent_q, sent_d;
    logic               busy_q;

    logic [BLOCK_W-1:0] fifo_head;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, cnt_nxt;
    logic               push, pop, load, done_acc;

    assign blk_ready_o = !fifo_full;
    assign push        = blk_valid_i && blk_ready_o;

    aes_block_uart_serializer_block_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (blk_data_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A done arriving while our own start pulse is still high belongs to an earlier byte.
    assign done_acc = tx_done_i && !tx_start_q;

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        sent_d     = sent_q;
        load       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_acc) begin
                    if (idx_q != IDX_W'(BYTES_PER_BLOCK - 1)) begin
                        idx_d      = idx_q + 1'b1;
                        tx_data_d  = sel_byte(blk_q, idx_d, LSB_FIRST);
                        tx_start_d = 1'b1;
                    end else begin
                        sent_d = sent_q + 16'd1;
                        if (!fifo_empty) load = 1'b1;
                        else             state_d = S_IDLE;
                    end
                end
            end
        endcase

        if (load) begin
            pop        = 1'b1;
            blk_d      = fifo_head;
            idx_d      = '0;
            tx_data_d  = sel_byte(fifo_head, '0, LSB_FIRST);
            tx_start_d = 1'b1;
        end
    end

    assign cnt_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            blk_q      <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            sent_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            sent_q     <= sent_d;
            busy_q     <= (state_d == S_WAIT) || (cnt_nxt != '0);
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_start_o    = tx_start_q;
    assign busy_o        = busy_q;
    assign blocks_sent_o = sent_q;

endmodule

// File: tb/tb_aes_block_uart_serializer.sv
// Scoreboard bench: an LSB-first and an MSB-first serializer share stimulus, each with its own UART model.
module tb_aes_block_uart_serializer;
    import aes_block_uart_serializer_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [BLOCK_W-1:0] blk_data = '0;
    logic               blk_valid = 1'b0;
    logic               inj_done = 1'b0;

    logic               rdy [2];
    logic               st [2];
    logic               busy [2];
    logic [7:0]         data [2];
    logic [15:0]        sent [2];
    logic               mdone [2] = '{1'b0, 1'b0};
    int                 cnt [2] = '{0, 0};
    int                 dly = 10;

    logic [7:0]         q [2][$];
    int                 starts [2] = '{0, 0};
    logic [15:0]        prev [2] = '{16'd0, 16'd0};
    int                 tests = 0, fails = 0;
    int                 acc_sent = 0;

    always #5 clk = ~clk;

    aes_block_uart_serializer #(.FIFO_DEPTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .blk_data_i(blk_data), .blk_valid_i(blk_valid),
        .blk_ready_o(rdy[0]), .tx_data_o(data[0]), .tx_start_o(st[0]),
        .tx_done_i(mdone[0] | inj_done), .busy_o(busy[0]), .blocks_sent_o(sent[0]));

    aes_block_uart_serializer #(.FIFO_DEPTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .blk_data_i(blk_data), .blk_valid_i(blk_valid),
        .blk_ready_o(rdy[1]), .tx_data_o(data[1]), .tx_start_o(st[1]),
        .tx_done_i(mdone[1] | inj_done), .busy_o(busy[1]), .blocks_sent_o(sent[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // UART model: done pulses a fixed number of cycles after each start; not cleared by DUT reset.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            mdone[u] <= 1'b0;
            if (st[u]) cnt[u] <= dly;
            else if (cnt[u] != 0) begin
                cnt[u] <= cnt[u] - 1;
                if (cnt[u] == 1) mdone[u] <= 1'b1;
            end
        end
    end

    // Monitor: every start pulse must carry the next expected byte; every block completion
    // must chain straight into the next queued block or leave the unit idle.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!reset) begin
                if (sent[u] == prev[u] + 16'd1) begin
                    if (q[u].size() != 0) chk($sformatf("b2b_start%0d", u), 32'(st[u]), 32'd1);
                    else begin
                        chk($sformatf("end_no_start%0d", u), 32'(st[u]), 32'd0);
                        chk($sformatf("busy_fall%0d", u), 32'(busy[u]), 32'd0);
                    end
                end
                if (st[u]) begin
                    starts[u]++;
                    if (q[u].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_start%0d: got byte %02h, required no start", u, data[u]);
                    end else chk($sformatf("byte%0d", u), 32'(data[u]), 32'(q[u].pop_front()));
                end
            end
            prev[u] = sent[u];
        end
    end

    task automatic send_block(input logic [BLOCK_W-1:0] b);
        int t = 0;
        @(negedge clk);
        blk_data  = b;
        blk_valid = 1'b1;
        while (!rdy[0] && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("accept_in_time", 32'(t < 4000), 32'd1);
        acc_sent = int'(sent[0]);
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            q[0].push_back(b[8*k +: 8]);
            q[1].push_back(b[8*(15-k) +: 8]);
        end
    endtask

    task automatic wait_sent(input int n);
        int t = 0;
        while (int'(sent[0]) != n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("blocks_sent", 32'(sent[0]), 32'(n));
        chk("blocks_sent_msb", 32'(sent[1]), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        blk_valid = 1'b0;
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_ready%0d", u), 32'(rdy[u]), 32'd1);
            chk($sformatf("rst_data%0d", u), 32'(data[u]), 32'd0);
            chk($sformatf("rst_start%0d", u), 32'(st[u]), 32'd0);
            chk($sformatf("rst_busy%0d", u), 32'(busy[u]), 32'd0);
            chk($sformatf("rst_sent%0d", u), 32'(sent[u]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BLOCK_W-1:0] b;
        int s0, s1, t;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_vals();

        // Single block: LSB instance emits 00..0F, MSB instance 0F..00.
        s0 = starts[0];
        s1 = starts[1];
        send_block(128'h0F0E0D0C0B0A09080706050403020100);
        @(negedge clk);
        blk_valid = 1'b0;
        chk("lat_after_e0", 32'(st[0]), 32'd0);
        chk("busy_after_push", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("lat_after_e1", 32'(st[0]), 32'd1);
        chk("first_byte_lsb", 32'(data[0]), 32'h00);
        chk("first_byte_msb", 32'(data[1]), 32'h0F);
        wait_sent(1);
        chk("busy_after_last_done", 32'(busy[0]), 32'd0);
        chk("pulses_lsb", 32'(starts[0] - s0), 32'd16);
        chk("pulses_msb", 32'(starts[1] - s1), 32'd16);

        // Done while idle: ignored.
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("idle_done_start", 32'(st[0]), 32'd0);
        @(negedge clk);
        chk("idle_done_start2", 32'(st[0]), 32'd0);
        chk("idle_done_sent", 32'(sent[0]), 32'd1);
        chk("idle_done_busy", 32'(busy[0]), 32'd0);

        // Done coincident with the byte0 start pulse: ignored.
        s0 = starts[0];
        send_block(128'hFFEEDDCCBBAA99887766554433221100);
        @(negedge clk);
        blk_valid = 1'b0;
        @(negedge clk);
        chk("coinc_start_seen", 32'(st[0]), 32'd1);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("coinc_done_ignored_lsb", 32'(st[0]), 32'd0);
        chk("coinc_done_ignored_msb", 32'(st[1]), 32'd0);
        wait_sent(2);
        chk("coinc_pulses", 32'(starts[0] - s0), 32'd16);

        // Backpressure: 6 blocks, slow UART.
        do_reset();
        dly = 20;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) b[8*k +: 8] = {4'(i), 4'(k)};
            if (i == 5) begin
                @(negedge clk);
                chk("ready_drop_lsb", 32'(rdy[0]), 32'd0);
                chk("ready_drop_msb", 32'(rdy[1]), 32'd0);
                chk("ready_drop_sent", 32'(sent[0]), 32'd0);
            end
            send_block(b);
            if (i == 5) chk("ready_rise_after_blk1", 32'(acc_sent), 32'd1);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        wait_sent(6);
        chk("bp_queue_empty", 32'(q[0].size() + q[1].size()), 32'd0);
        chk("bp_ready_end", 32'(rdy[0]), 32'd1);

        // Reset mid-block after byte 5.
        do_reset();
        dly = 10;
        s0 = starts[0];
        send_block(128'h0123456789ABCDEFFEDCBA9876543210);
        @(negedge clk);
        blk_valid = 1'b0;
        t = 0;
        while (starts[0] - s0 < 6 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("reached_byte5", 32'(starts[0] - s0), 32'd6);
        repeat (2) @(negedge clk);
        do_reset();
        check_reset_vals();
        repeat (20) @(negedge clk);
        chk("post_rst_start", 32'(st[0]), 32'd0);
        chk("post_rst_busy", 32'(busy[0]), 32'd0);
        chk("post_rst_sent", 32'(sent[0]), 32'd0);
        s0 = starts[0];
        send_block(128'h3C3C3C3C_A5A5A5A5_5A5A5A5A_C3C3C3C3);
        @(negedge clk);
        blk_valid = 1'b0;
        wait_sent(1);
        chk("post_rst_pulses", 32'(starts[0] - s0), 32'd16);
        chk("post_rst_queue_empty", 32'(q[0].size() + q[1].size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
